// File: rtl/mac_accum_pkg.sv
// mac_accum_pkg: shared fixed-point parameters and framing state type for the MAC stage.
package mac_accum_pkg;

    localparam int DWIDTH = 16;
    localparam int FL     = 8;
    localparam int GUARD  = 8;
    localparam int PROD_W = 2 * DWIDTH;
    localparam int ACC_W  = 2 * DWIDTH + GUARD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } frame_state_t;

endpackage

// File: rtl/mac_mult.sv
// mac_mult: registered signed multiplier with valid/first/last passthrough.
module mac_mult #(
    parameter int DWIDTH = 16
) (
    input  logic                       clk,
    input  logic                       xrst,
    input  logic                       i_valid,
    input  logic                       i_first,
    input  logic                       i_last,
    input  logic signed [DWIDTH-1:0]   i_a,
    input  logic signed [DWIDTH-1:0]   i_b,
    output logic signed [2*DWIDTH-1:0] o_prod,
    output logic                       o_valid,
    output logic                       o_first,
    output logic                       o_last
);
    localparam int PW = 2 * DWIDTH;

    logic signed [PW-1:0] r_prod;
    logic                 r_valid;
    logic                 r_first;
    logic                 r_last;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_prod  <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_prod  <= PW'(i_a) * PW'(i_b);
                r_first <= i_first;
                r_last  <= i_last;
            end
        end
    end

    assign o_prod  = r_prod;
    assign o_valid = r_valid;
    assign o_first = r_first;
    assign o_last  = r_last;

endmodule

// File: rtl/mac_accum.sv
// mac_accum: three-stage fixed-point MAC (multiply, accumulate, scale) with first/last framing.
// Define MAC_SAT_EN to clamp the scaled result instead of keeping its low DWIDTH bits.
module mac_accum
    import mac_accum_pkg::*;
(
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     in_valid,
    input  logic                     first,
    input  logic                     last,
    input  logic signed [DWIDTH-1:0] pixel,
    input  logic signed [DWIDTH-1:0] weight,
    output logic signed [DWIDTH-1:0] pixel_out,
    output logic                     out_valid,
    output logic                     err
);
    frame_state_t              r_state;
    frame_state_t              w_state_nxt;
    logic                      w_accept;
    logic                      w_err_evt;
    logic signed [PROD_W-1:0]  w_prod;
    logic                      w_v1;
    logic                      w_f1;
    logic                      w_l1;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_v2;
    logic signed [DWIDTH-1:0]  w_scaled;
    logic signed [DWIDTH-1:0]  r_pixel_out;
    logic                      r_out_valid;
    logic                      r_err;

    // Beats arriving in IDLE without first are dropped before the multiplier.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_evt   = 1'b0;
        if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_accept  = first;
                    w_err_evt = ~first;
                end
                ST_ACC: begin
                    w_accept  = 1'b1;
                    w_err_evt = first;
                end
            endcase
            if (w_accept) begin
                w_state_nxt = last ? ST_IDLE : ST_ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    mac_mult #(
        .DWIDTH (DWIDTH)
    ) u_mult (
        .clk     (clk),
        .xrst    (xrst),
        .i_valid (w_accept),
        .i_first (first),
        .i_last  (last),
        .i_a     (pixel),
        .i_b     (weight),
        .o_prod  (w_prod),
        .o_valid (w_v1),
        .o_first (w_f1),
        .o_last  (w_l1)
    );

    assign w_prod_ext = {{GUARD{w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_acc <= '0;
            r_v2  <= 1'b0;
        end else begin
            if (w_v1) begin
                r_acc <= w_f1 ? w_prod_ext : r_acc + w_prod_ext;
            end
            r_v2 <= w_v1 & w_l1;
        end
    end

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DWIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic signed [ACC_W-1:0] w_shift;

    always_comb begin
        w_shift = r_acc >>> FL;
        if (w_shift > SAT_HI) begin
            w_scaled = SAT_HI[DWIDTH-1:0];
        end else if (w_shift < SAT_LO) begin
            w_scaled = SAT_LO[DWIDTH-1:0];
        end else begin
            w_scaled = w_shift[DWIDTH-1:0];
        end
    end
`else
    // Low DWIDTH bits of (acc >>> FL) are exactly this slice of acc.
    always_comb begin
        w_scaled = r_acc[FL +: DWIDTH];
    end
`endif

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_pixel_out <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_pixel_out <= w_scaled;
            end
        end
    end

    assign pixel_out = r_pixel_out;
    assign out_valid = r_out_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed and randomized checks of mac_accum against a frame-level reference model.
module tb_mac_accum;
    localparam int DW = 16;

`ifdef MAC_SAT_EN
    localparam int OVF_EXP = 32767;
`else
    localparam int OVF_EXP = -256;
`endif

    logic                 clk = 1'b0;
    logic                 xrst;
    logic                 in_valid;
    logic                 first;
    logic                 last;
    logic signed [DW-1:0] pixel;
    logic signed [DW-1:0] weight;
    logic signed [DW-1:0] pixel_out;
    logic                 out_valid;
    logic                 err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int obs_val_q[$];
    int obs_cyc_q[$];
    int exp_val_q[$];
    int exp_cyc_q[$];

    bit     m_inframe;
    bit     m_err;
    longint m_sum;

    mac_accum dut (
        .clk       (clk),
        .xrst      (xrst),
        .in_valid  (in_valid),
        .first     (first),
        .last      (last),
        .pixel     (pixel),
        .weight    (weight),
        .pixel_out (pixel_out),
        .out_valid (out_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (xrst === 1'b1 && out_valid === 1'b1) begin
            obs_val_q.push_back(int'(pixel_out));
            obs_cyc_q.push_back(cyc);
        end
    end

    // 40-bit two's complement wrap of the accumulator
    function automatic longint wrap_acc(input longint x);
        longint y;
        y = x <<< 24;
        return y >>> 24;
    endfunction

    function automatic int ref_scale(input longint s);
        longint q;
        q = s >>> 8;
`ifdef MAC_SAT_EN
        if (q > 32767) return 32767;
        if (q < -32768) return -32768;
        return int'(q);
`else
        return int'(shortint'(q));
`endif
    endfunction

    function automatic void model_beat(input bit f, input bit l, input int p, input int w);
        if (!m_inframe && !f) begin
            m_err = 1'b1;
        end else begin
            if (m_inframe && f) m_err = 1'b1;
            if (f) m_sum = longint'(p) * longint'(w);
            else   m_sum = wrap_acc(m_sum + longint'(p) * longint'(w));
            m_inframe = !l;
            if (l) begin
                exp_val_q.push_back(ref_scale(m_sum));
                exp_cyc_q.push_back(cyc + 3);
            end
        end
    endfunction

    function automatic void model_reset();
        m_inframe = 1'b0;
        m_err     = 1'b0;
        m_sum     = 0;
        exp_val_q.delete();
        exp_cyc_q.delete();
    endfunction

    function automatic void clear_q();
        obs_val_q.delete();
        obs_cyc_q.delete();
        exp_val_q.delete();
        exp_cyc_q.delete();
    endfunction

    function automatic int rnd_op();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 2047)) - 1024;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drive(input bit v, input bit f, input bit l, input int p, input int w);
        @(posedge clk);
        #1;
        in_valid = v;
        first    = f;
        last     = l;
        pixel    = DW'(p);
        weight   = DW'(w);
        if (v) model_beat(f, l, p, w);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        xrst     = 1'b0;
        in_valid = 1'b0;
        first    = 1'b0;
        last     = 1'b0;
        pixel    = '0;
        weight   = '0;
        model_reset();
        #1;
        checks++;
        if (pixel_out !== 16'sd0) begin
            failures++;
            $display("FAIL reset pixel_out: got %0d expected 0", pixel_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset err: got %b expected 0", err);
        end
        repeat (3) @(posedge clk);
        #1;
        xrst = 1'b1;
        clear_q();
        idle(4);
        checks++;
        if (obs_val_q.size() != 0) begin
            failures++;
            $display("FAIL reset idle output count: got %0d expected 0", obs_val_q.size());
        end
    endtask

    task automatic test_single();
        int tp[4];
        int tw[4];
        int te[4];
        int t0;
        tp = '{256, -1, 1, 32767};
        tw = '{512, 1, 1, 32767};
        te = '{512, -1, 0, OVF_EXP};
        for (int i = 0; i < 4; i++) begin
            clear_q();
            drive(1'b1, 1'b1, 1'b1, tp[i], tw[i]);
            t0 = cyc;
            idle(5);
            checks++;
            if (obs_val_q.size() != 1) begin
                failures++;
                $display("FAIL single[%0d] output count: got %0d expected 1", i, obs_val_q.size());
            end else begin
                checks++;
                if (obs_val_q[0] != te[i]) begin
                    failures++;
                    $display("FAIL single[%0d] pixel_out: got %0d expected %0d", i, obs_val_q[0], te[i]);
                end
                checks++;
                if (obs_cyc_q[0] != t0 + 3) begin
                    failures++;
                    $display("FAIL single[%0d] latency: got %0d expected 3", i, obs_cyc_q[0] - t0);
                end
            end
        end
    endtask

    task automatic test_bubbles();
        int t0;
        clear_q();
        drive(1'b1, 1'b1, 1'b0, 256, 256);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 512, 256);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, -256, 256);
        t0 = cyc;
        idle(6);
        checks++;
        if (obs_val_q.size() != 1) begin
            failures++;
            $display("FAIL bubbles output count: got %0d expected 1", obs_val_q.size());
        end else begin
            checks++;
            if (obs_val_q[0] != 512 || obs_cyc_q[0] != t0 + 3) begin
                failures++;
                $display("FAIL bubbles result: got %0d at +%0d expected 512 at +3",
                         obs_val_q[0], obs_cyc_q[0] - t0);
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL bubbles err: got %b expected 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        clear_q();
        for (int fr = 0; fr < 30; fr++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                drive(1'b1, k == 0, k == len - 1, rnd_op(), rnd_op());
                if (k != len - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(6);
        checks++;
        if (obs_val_q.size() != exp_val_q.size()) begin
            failures++;
            $display("FAIL b2b output count: got %0d expected %0d", obs_val_q.size(), exp_val_q.size());
        end else begin
            foreach (exp_val_q[i]) begin
                checks++;
                if (obs_val_q[i] != exp_val_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
                    failures++;
                    $display("FAIL b2b result[%0d]: got %0d @%0d expected %0d @%0d",
                             i, obs_val_q[i], obs_cyc_q[i], exp_val_q[i], exp_cyc_q[i]);
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL b2b err: got %b expected 0", err);
        end
    endtask

    task automatic test_protocol();
        clear_q();
        drive(1'b1, 1'b0, 1'b0, 100, 100);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL protocol err early: got %b expected 0", err);
        end
        idle(1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL protocol err after stray beat: got %b expected 1", err);
        end
        idle(4);
        checks++;
        if (obs_val_q.size() != 0) begin
            failures++;
            $display("FAIL protocol stray output count: got %0d expected 0", obs_val_q.size());
        end
        drive(1'b1, 1'b1, 1'b0, 300, 200);
        drive(1'b1, 1'b0, 1'b0, 400, -50);
        drive(1'b1, 1'b1, 1'b0, 256, 256);
        drive(1'b1, 1'b0, 1'b1, 256, 512);
        idle(2);
        drive(1'b1, 1'b1, 1'b1, 512, 512);
        idle(6);
        checks++;
        if (obs_val_q.size() != 2) begin
            failures++;
            $display("FAIL protocol output count: got %0d expected 2", obs_val_q.size());
        end else begin
            checks++;
            if (obs_val_q[0] != 768 || obs_val_q[1] != 1024) begin
                failures++;
                $display("FAIL protocol results: got %0d,%0d expected 768,1024", obs_val_q[0], obs_val_q[1]);
            end
            checks++;
            if (exp_cyc_q.size() != 2 || obs_cyc_q[0] != exp_cyc_q[0] || obs_cyc_q[1] != exp_cyc_q[1]) begin
                failures++;
                $display("FAIL protocol timing: got %0d,%0d expected model cycles", obs_cyc_q[0], obs_cyc_q[1]);
            end
        end
        checks++;
        if (err !== m_err || err !== 1'b1) begin
            failures++;
            $display("FAIL protocol err sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_reset_midframe();
        int t0;
        clear_q();
        drive(1'b1, 1'b1, 1'b1, 1000, 700);
        idle(5);
        checks++;
        if (pixel_out !== 16'sd2734) begin
            failures++;
            $display("FAIL midreset pre-result: got %0d expected 2734", pixel_out);
        end
        clear_q();
        drive(1'b1, 1'b1, 1'b0, 300, 300);
        drive(1'b1, 1'b0, 1'b0, 300, 300);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        first    = 1'b0;
        last     = 1'b0;
        xrst     = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pixel_out !== 16'sd0 || out_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midreset outputs: got pixel_out=%0d out_valid=%b err=%b expected 0/0/0",
                     pixel_out, out_valid, err);
        end
        @(posedge clk);
        #1;
        xrst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 300, 300);
        idle(1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL midreset dropped-last err: got %b expected 1", err);
        end
        drive(1'b1, 1'b1, 1'b1, 256, 512);
        t0 = cyc;
        idle(5);
        checks++;
        if (obs_val_q.size() != 1) begin
            failures++;
            $display("FAIL midreset output count: got %0d expected 1", obs_val_q.size());
        end else begin
            checks++;
            if (obs_val_q[0] != 512 || obs_cyc_q[0] != t0 + 3) begin
                failures++;
                $display("FAIL midreset fresh frame: got %0d at +%0d expected 512 at +3",
                         obs_val_q[0], obs_cyc_q[0] - t0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bubbles();
        test_back_to_back();
        test_protocol();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_accum.md
# mac_accum

Fixed-point multiply-accumulate stage that computes one dot-product term stream (pixel × weight) per output and feeds the bias stage's `pixel_in`. It sits directly upstream of the bias-add stage in each LSTM gate datapath. Each input beat carries one operand pair, and framing flags mark the first and last term. One scaled, width-reduced result is emitted per frame, with a single-cycle `out_valid` that the gate controller uses to time the bias stage's `out_en`.

## Interface
- `DWIDTH`, 16, operand/result width (signed two's complement)
- `FL`, 8, fractional bits of the fixed-point format (1.0 = 2^FL)
- `GUARD`, 8, extra accumulator headroom bits; `ACC_W = 2*DWIDTH + GUARD`

Ports:
- `clk` in 1: clock, rising edge
- `xrst` in 1: reset, asynchronous, active-low
- `in_valid` in 1: operand pair valid this cycle
- `first` in 1: beat is first term of a frame (qualified by `in_valid`)
- `last` in 1: beat is last term of a frame (qualified by `in_valid`)
- `pixel` in DWIDTH: signed operand
- `weight` in DWIDTH: signed operand
- `pixel_out` out DWIDTH: signed result, held until next result
- `out_valid` out 1: one-cycle pulse, `pixel_out` updated this cycle
- `err` out 1: sticky protocol error, cleared only by reset

## Operation
- Stage 1 (MUL): register `prod = pixel * weight` (2*DWIDTH, signed), plus `v1`, `f1`, `l1`.
- Stage 2 (ACC): if `v1`: `acc = f1 ? sext(prod) : acc + sext(prod)`, ACC_W bits, wraps silently on overflow; registers `v2 = v1 & l1`.
- Stage 3 (OUT): if `v2`: `pixel_out = scale(acc >>> FL)`. The shift is arithmetic (truncation toward −inf, no rounding). `out_valid = v2`.
- Framing FSM (on accepted beats, `in_valid=1`):
  - IDLE + `first` → ACC. IDLE + `first&last` → stays IDLE and the single-term frame is emitted.
  - IDLE + not `first` → beat dropped (not forwarded to stage 1), `err` ← 1.
  - ACC + `last` → IDLE.
  - ACC + `first` (without prior `last`) → restart: the accumulator reloads, the partial frame is discarded with no output, and `err` ← 1.
  - ACC + `first&last` → single-term frame emitted; same `err` rule as ACC + `first`.
- `in_valid=0` cycles are bubbles: the accumulator and FSM hold, and any number of bubbles is allowed between terms.
- Back-to-back frames (`last` then `first` on the next cycle) are supported at full rate with no dead cycles.
- Reset values: `pixel_out`=0, `out_valid`=0, `err`=0, FSM=IDLE, `acc`=0, all pipeline valids 0.
- Reset asserted mid-frame aborts the frame. In-flight results are lost, and no `out_valid` is produced for that frame.

## Timing
- Throughput: 1 term/cycle.
- Latency: beat with `last` at cycle t → `out_valid` at t+3.
- `pixel_out` is stable from the `out_valid` cycle until the next `out_valid`.
- `err` rises the cycle after the offending beat.

## Configuration
- `MAC_SAT_EN` defined: scale clamps `acc >>> FL` to [−2^(DWIDTH−1), 2^(DWIDTH−1)−1].
- `MAC_SAT_EN` undefined: scale keeps the low DWIDTH bits (wrap). The accumulator wraps at ACC_W in both cases.

## Structure
- The shared parameters package holds DWIDTH, FL and GUARD, the derived ACC_W, and the framing state typedef (IDLE, ACC).
- One sub-module, `mac_mult`: registered signed multiplier (stage 1) with valid/flag passthrough, reusable by other gate datapaths.

## Test plan
Conditions: DWIDTH=16, FL=8.
- Single term: `first=last=1`, pixel=256, weight=512 → `out_valid` 3 cycles later, `pixel_out`=512.
- Three-term frame with two bubbles between beats: (256,256), (512,256), (−256,256) → one `out_valid`, `pixel_out`=512, `err`=0.
- Negative truncation: single term pixel=−1, weight=1 → `pixel_out`=−1. Single term pixel=1, weight=1 → `pixel_out`=0.
- Overflow: single term 32767×32767 → with `MAC_SAT_EN` `pixel_out`=32767; without it `pixel_out`=−256 (0xFF00).
- Protocol: beat without `first` in IDLE → no output, `err`=1 and stays 1. `first` mid-frame → partial frame discarded, the new frame's result is correct, `err`=1.
- Reset mid-frame: `xrst` low for 1 cycle after 2 terms → `pixel_out`=0, `out_valid`=0. The following `last` beat is dropped with `err`=1. A fresh framed beat then yields the correct result.
